// File: rtl/seq_det_pkg.sv
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Elaboration-time helpers for the parametrised KMP pattern
//                detector (state width, next-state and failure functions).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int SEQ_DET_PAT_W_MAX = 16;
    localparam int SEQ_DET_CNT_W_MAX = 32;

    // Width of the matched-prefix counter and of state_o.
    function automatic int seq_det_sw(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic seq_det_bit(input logic [15:0] pattern, input int pat_w,
                                         input int i);
        logic [15:0] t;
        t = pattern >> (pat_w - 1 - i);
        return t[0];
    endfunction

    // Longest proper pattern prefix that is a suffix of (prefix[0..s-1], x).
    function automatic int seq_det_next(input logic [15:0] pattern, input int pat_w,
                                        input int s, input logic x);
        int   best;
        int   j;
        logic ok;
        logic sym;
        best = 0;
        for (int k = 1; k < SEQ_DET_PAT_W_MAX; k++) begin
            if (k <= s + 1 && k < pat_w) begin
                ok = 1'b1;
                for (int i = 0; i < SEQ_DET_PAT_W_MAX; i++) begin
                    if (i < k) begin
                        j   = s + 1 - k + i;
                        sym = (j == s) ? x : seq_det_bit(pattern, pat_w, j);
                        if (sym != seq_det_bit(pattern, pat_w, i)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

    // Resume point after a full match when overlapping matches are allowed.
    function automatic int seq_det_fail(input logic [15:0] pattern, input int pat_w);
        return seq_det_next(pattern, pat_w, pat_w - 1,
                            seq_det_bit(pattern, pat_w, pat_w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_if.sv
// ============================================================================
//  Module      : seq_det_if
//  Description : Serial-bit / match-status bundle of the pattern detector.
//                Counter signals exist only when SEQ_DET_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_det_if #(
    parameter int SW = seq_det_pkg::seq_det_sw(3)
`ifdef SEQ_DET_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
);

    logic          en;
    logic          x;
    logic          y_mealy;
    logic          y_moore;
    logic [SW-1:0] state_o;
`ifdef SEQ_DET_CNT_EN
    logic             clr_cnt;
    logic [CNT_W-1:0] match_cnt;

    modport master (output en, output x, output clr_cnt,
                    input y_mealy, input y_moore, input state_o, input match_cnt);
    modport slave  (input en, input x, input clr_cnt,
                    output y_mealy, output y_moore, output state_o, output match_cnt);
`else
    modport master (output en, output x,
                    input y_mealy, input y_moore, input state_o);
    modport slave  (input en, input x,
                    output y_mealy, output y_moore, output state_o);
`endif

endinterface

`default_nettype wire

// File: rtl/seq_det_match_cnt.sv
// ============================================================================
//  Module      : seq_det_match_cnt
//  Description : Saturating match counter with synchronous clear; a clear
//                coinciding with a match leaves the count at 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_match_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (CNT_W < 1 || CNT_W > SEQ_DET_CNT_W_MAX) begin : g_bad_cnt_w
        $error("seq_det_match_cnt: CNT_W out of range");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/seq_det_param.sv
// ============================================================================
//  Module      : seq_det_param
//  Description : Parametrised serial pattern detector built as a KMP automaton
//                with Mealy and Moore match outputs. Define SEQ_DET_CNT_EN to
//                add the saturating match counter (clr_cnt / match_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic  clk,
    input  logic  rst,
    seq_det_if.slave bus
);

    localparam int            SW      = seq_det_sw(PAT_W);
    localparam int            ROM_D   = 2 ** SW;
    localparam logic [SW-1:0] LAST    = SW'(PAT_W - 1);
    localparam logic [15:0]   PAT_EXT = 16'(PATTERN);

    if (PAT_W < 1 || PAT_W > SEQ_DET_PAT_W_MAX || CNT_W < 1 || CNT_W > SEQ_DET_CNT_W_MAX)
    begin : g_bad_param
        $error("seq_det_param: PAT_W or CNT_W out of range");
    end

    logic [SW-1:0] nxt0_rom [ROM_D];
    logic [SW-1:0] nxt1_rom [ROM_D];
    logic          exp_rom  [ROM_D];

    // Transition table fully resolved at elaboration; rows past PAT_W-1 are unreachable.
    for (genvar gs = 0; gs < ROM_D; gs++) begin : g_rom
        if (gs < PAT_W) begin : g_live
            localparam int N0 = seq_det_next(PAT_EXT, PAT_W, gs, 1'b0);
            localparam int N1 = seq_det_next(PAT_EXT, PAT_W, gs, 1'b1);
            assign nxt0_rom[gs] = SW'(N0);
            assign nxt1_rom[gs] = SW'(N1);
            assign exp_rom[gs]  = seq_det_bit(PAT_EXT, PAT_W, gs);
        end else begin : g_pad
            assign nxt0_rom[gs] = '0;
            assign nxt1_rom[gs] = '0;
            assign exp_rom[gs]  = 1'b0;
        end
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          y_moore_q;
    logic          y_moore_d;
    logic          exp_bit;
    logic          match_now;

    always_comb begin
        exp_bit   = exp_rom[state_q];
        match_now = bus.en && (state_q == LAST) && (bus.x == exp_bit);
        y_moore_d = match_now;
        state_d   = state_q;
        if (bus.en) begin
            // A full match in non-overlapping mode restarts from scratch.
            if (match_now && !OVERLAP) begin
                state_d = '0;
            end else if (bus.x) begin
                state_d = nxt1_rom[state_q];
            end else begin
                state_d = nxt0_rom[state_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= '0;
            y_moore_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_moore_q <= y_moore_d;
        end
    end

    assign bus.y_mealy = match_now & rst;
    assign bus.y_moore = y_moore_q;
    assign bus.state_o = state_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] match_cnt_w;

    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr_cnt),
        .inc (match_now),
        .cnt (match_cnt_w)
    );

    assign bus.match_cnt = match_cnt_w;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_det_param.sv
// ============================================================================
//  Module      : tb_seq_det_param
//  Description : Bench for seq_det_param: four parameter sets, directed vector
//                table plus randomized stream against a history-based model.
//                Counter checks are active when SEQ_DET_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_det_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_det_if #(.SW(2)) ifa ();
    seq_det_if #(.SW(2)) ifb ();
    seq_det_if #(.SW(3)) ifc ();
`ifdef SEQ_DET_CNT_EN
    seq_det_if #(.SW(1), .CNT_W(2)) ifd ();
`else
    seq_det_if #(.SW(1)) ifd ();
`endif

    seq_det_param #(.PAT_W(3), .PATTERN(3'b101),  .OVERLAP(1'b1), .CNT_W(8))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_det_param #(.PAT_W(3), .PATTERN(3'b101),  .OVERLAP(1'b0), .CNT_W(8))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_det_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8))
        u_c (.clk(clk), .rst(rst), .bus(ifc));
    seq_det_param #(.PAT_W(1), .PATTERN(1'b1),    .OVERLAP(1'b1), .CNT_W(2))
        u_d (.clk(clk), .rst(rst), .bus(ifd));

    logic        drv_en  [4];
    logic        drv_x   [4];
    logic        got_me  [4];
    logic        got_mo  [4];
    logic [31:0] got_st  [4];

    assign ifa.en = drv_en[0];  assign ifa.x = drv_x[0];
    assign ifb.en = drv_en[1];  assign ifb.x = drv_x[1];
    assign ifc.en = drv_en[2];  assign ifc.x = drv_x[2];
    assign ifd.en = drv_en[3];  assign ifd.x = drv_x[3];
    assign got_me[0] = ifa.y_mealy;  assign got_mo[0] = ifa.y_moore;  assign got_st[0] = 32'(ifa.state_o);
    assign got_me[1] = ifb.y_mealy;  assign got_mo[1] = ifb.y_moore;  assign got_st[1] = 32'(ifb.state_o);
    assign got_me[2] = ifc.y_mealy;  assign got_mo[2] = ifc.y_moore;  assign got_st[2] = 32'(ifc.state_o);
    assign got_me[3] = ifd.y_mealy;  assign got_mo[3] = ifd.y_moore;  assign got_st[3] = 32'(ifd.state_o);

    logic        drv_clr [4];
`ifdef SEQ_DET_CNT_EN
    logic [31:0] got_cnt [4];
    assign ifa.clr_cnt = drv_clr[0];  assign got_cnt[0] = 32'(ifa.match_cnt);
    assign ifb.clr_cnt = drv_clr[1];  assign got_cnt[1] = 32'(ifb.match_cnt);
    assign ifc.clr_cnt = drv_clr[2];  assign got_cnt[2] = 32'(ifc.match_cnt);
    assign ifd.clr_cnt = drv_clr[3];  assign got_cnt[3] = 32'(ifd.match_cnt);
`endif

    // Reference model: pattern parameters and recent accepted-bit history.
    int          pw   [4] = '{3, 3, 4, 1};
    logic [15:0] pat  [4] = '{16'h5, 16'h5, 16'hD, 16'h1};
    bit          ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          cmax [4] = '{255, 255, 255, 3};
    bit          hist [4][$];
    int          cnt_m [4];

    int  exp_me  [4];
    int  exp_st  [4];
    int  exp_cnt [4];
    bit  chk_on  [4];
    int  n_pass = 0;
    int  n_total = 0;

    typedef struct {
        int d;
        bit rb;
        bit en;
        bit x;
        bit clr;
        bit m;
        int st;
        int cnt;
    } vec_t;

    vec_t vecs [30];

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[dut%0d] @%0t: got %0d, expected %0d", name, d, $time, act, exp);
        end
    endtask

    function automatic bit pbit(input int d, input int i);
        logic [15:0] t;
        t = pat[d] >> (pw[d] - 1 - i);
        return t[0];
    endfunction

    // Match = the last PAT_W accepted bits spell the pattern.
    task automatic model_edge(input int d, input bit en, input bit x, input bit clr,
                              output bit m);
        int n;
        m = 1'b0;
        if (en) begin
            hist[d].push_back(x);
            n = hist[d].size();
            if (n >= pw[d]) begin
                m = 1'b1;
                for (int i = 0; i < pw[d]; i++) begin
                    if (hist[d][n - pw[d] + i] != pbit(d, i)) m = 1'b0;
                end
            end
            if (m && !ov[d]) hist[d].delete();
            while (hist[d].size() > pw[d]) hist[d].delete(0);
        end
        if (clr) cnt_m[d] = m ? 1 : 0;
        else if (m && cnt_m[d] < cmax[d]) cnt_m[d]++;
    endtask

    // State = longest proper prefix of the pattern ending the history.
    function automatic int model_state(input int d);
        int n;
        int best;
        bit ok;
        n = hist[d].size();
        best = 0;
        for (int k = 1; k < pw[d]; k++) begin
            if (k <= n) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (hist[d][n - k + i] != pbit(d, i)) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            if (chk_on[d]) chk("y_mealy", d, int'(got_me[d]), exp_me[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            if (chk_on[d]) begin
                chk("y_moore", d, int'(got_mo[d]), exp_me[d]);
                chk("state_o", d, int'(got_st[d]), exp_st[d]);
`ifdef SEQ_DET_CNT_EN
                chk("match_cnt", d, int'(got_cnt[d]), exp_cnt[d]);
`endif
            end
        end
    endtask

    // Assert reset with a match-worthy input applied, check outputs, release.
    task automatic do_reset();
        for (int d = 0; d < 4; d++) begin
            drv_en[d]  = 1'b1;
            drv_x[d]   = 1'b1;
            drv_clr[d] = 1'b0;
        end
        rst = 1'b0;
        #2;
        for (int d = 0; d < 4; d++) begin
            chk("rst_y_mealy", d, int'(got_me[d]), 0);
            chk("rst_y_moore", d, int'(got_mo[d]), 0);
            chk("rst_state_o", d, int'(got_st[d]), 0);
`ifdef SEQ_DET_CNT_EN
            chk("rst_match_cnt", d, int'(got_cnt[d]), 0);
`endif
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) drv_en[d] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            hist[d].delete();
            cnt_m[d] = 0;
        end
    endtask

    task automatic drive_one(input int d, input bit en, input bit x, input bit clr,
                             input bit m, input int st, input int cnt);
        for (int k = 0; k < 4; k++) begin
            drv_en[k]  = 1'b0;
            drv_clr[k] = 1'b0;
            chk_on[k]  = 1'b0;
        end
        drv_en[d]  = en;
        drv_x[d]   = x;
        drv_clr[d] = clr;
        chk_on[d]  = 1'b1;
        exp_me[d]  = int'(m);
        exp_st[d]  = st;
        exp_cnt[d] = cnt;
        step();
    endtask

    initial begin
        bit m;
        for (int d = 0; d < 4; d++) begin
            drv_en[d] = 1'b0; drv_x[d] = 1'b0; drv_clr[d] = 1'b0; chk_on[d] = 1'b0;
            exp_me[d] = 0; exp_st[d] = 0; exp_cnt[d] = 0; cnt_m[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        //          d  rb en x  clr m  st cnt
        vecs = '{
            '{0, 1, 1, 1, 0, 0, 1, 0}, '{0, 0, 1, 0, 0, 0, 2, 0}, '{0, 0, 1, 1, 0, 1, 1, 1},
            '{0, 0, 1, 0, 0, 0, 2, 1}, '{0, 0, 1, 1, 0, 1, 1, 2}, '{0, 0, 0, 0, 0, 0, 1, 2},
            '{1, 1, 1, 1, 0, 0, 1, 0}, '{1, 0, 1, 0, 0, 0, 2, 0}, '{1, 0, 1, 1, 0, 1, 0, 1},
            '{1, 0, 1, 0, 0, 0, 0, 1}, '{1, 0, 1, 1, 0, 0, 1, 1},
            '{2, 1, 1, 1, 0, 0, 1, 0}, '{2, 0, 1, 1, 0, 0, 2, 0}, '{2, 0, 1, 1, 0, 0, 2, 0},
            '{2, 0, 1, 0, 0, 0, 3, 0}, '{2, 0, 1, 1, 0, 1, 1, 1},
            '{0, 1, 1, 1, 0, 0, 1, 0}, '{0, 0, 0, 1, 0, 0, 1, 0}, '{0, 0, 1, 0, 0, 0, 2, 0},
            '{0, 0, 0, 1, 0, 0, 2, 0}, '{0, 0, 1, 1, 0, 1, 1, 1}, '{0, 0, 0, 0, 0, 0, 1, 1},
            '{3, 1, 1, 1, 0, 1, 0, 1}, '{3, 0, 1, 1, 0, 1, 0, 2}, '{3, 0, 1, 1, 0, 1, 0, 3},
            '{3, 0, 1, 1, 0, 1, 0, 3}, '{3, 0, 1, 1, 0, 1, 0, 3}, '{3, 0, 1, 1, 1, 1, 0, 1},
            '{3, 0, 1, 0, 0, 0, 0, 1}, '{3, 0, 0, 0, 1, 0, 0, 0}
        };
        for (int i = 0; i < 30; i++) begin
            if (vecs[i].rb) do_reset();
            drive_one(vecs[i].d, vecs[i].en, vecs[i].x, vecs[i].clr,
                      vecs[i].m, vecs[i].st, vecs[i].cnt);
        end

        // Reset in the middle of a partial "10" discards it.
        do_reset();
        drive_one(0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
        drive_one(0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
        do_reset();
        drive_one(0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);

        // Randomized stream on all four instances against the model.
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc % 150 == 149) do_reset();
            for (int d = 0; d < 4; d++) begin
                drv_en[d]  = ($urandom_range(0, 3) != 0);
                drv_x[d]   = 1'($urandom_range(0, 1));
                drv_clr[d] = ($urandom_range(0, 15) == 0);
`ifndef SEQ_DET_CNT_EN
                drv_clr[d] = 1'b0;
`endif
                model_edge(d, drv_en[d], drv_x[d], drv_clr[d], m);
                exp_me[d]  = int'(m);
                exp_st[d]  = model_state(d);
                exp_cnt[d] = cnt_m[d];
                chk_on[d]  = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
